// File: rtl/riscv_pkg.sv
// riscv_pkg: register-file widths and the writeback request type shared by
// the writeback arbiter and its long-latency result buffer.
package riscv_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // One pending register-file write: destination index plus result.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // x0 is hard-wired to zero, so writes to it and queries of it are ignored.
  function automatic logic is_zero_rd(input logic [ADDR_W-1:0] rd);
    return rd == REG_ZERO;
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: bundles the pipeline, long-latency, ID query and
// register-file write signals around the writeback arbiter.
// The master side is the surrounding core; the slave side is the arbiter.
interface writeback_arbiter_if;
  import riscv_pkg::*;

  // In-order ALU/MEM pipeline writeback (never stalls)
  logic              AluValid;
  logic [ADDR_W-1:0] AluRd;
  logic [DATA_W-1:0] AluData;

  // Long-latency unit result handshake
  logic              LsuValid;
  logic [ADDR_W-1:0] LsuRd;
  logic [DATA_W-1:0] LsuData;
  logic              LsuReady;

  // ID stage: issue of long-latency ops and RAW hazard queries
  logic              IssueValid;
  logic [ADDR_W-1:0] IssueRd;
  logic [ADDR_W-1:0] QueryRs1;
  logic [ADDR_W-1:0] QueryRs2;
  logic              Rs1Pending;
  logic              Rs2Pending;
  logic              AluStall;

  // Register file write port
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;

  modport master (
    output AluValid, AluRd, AluData,
    output LsuValid, LsuRd, LsuData,
    input  LsuReady,
    output IssueValid, IssueRd, QueryRs1, QueryRs2,
    input  Rs1Pending, Rs2Pending, AluStall,
    input  RegWrite, WriteRegister, WriteData
  );

  modport slave (
    input  AluValid, AluRd, AluData,
    input  LsuValid, LsuRd, LsuData,
    output LsuReady,
    input  IssueValid, IssueRd, QueryRs1, QueryRs2,
    output Rs1Pending, Rs2Pending, AluStall,
    output RegWrite, WriteRegister, WriteData
  );

endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO of writeback requests used to park
// long-latency results while the pipeline owns the register-file port.
// The head entry is visible combinationally so the arbiter can pick it.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_push,
  input  wb_req_t i_data,
  input  logic    i_pop,
  output wb_req_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  wb_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  logic w_doPush;
  logic w_doPop;

  assign o_full   = (r_count == CNT_FULL);
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_head   = r_mem[r_rdPtr];

  // Storage array: contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointers wrap modulo DEPTH; reset discards all buffered entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= (r_wrPtr == PTR_LAST) ? '0 : r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= (r_rdPtr == PTR_LAST) ? '0 : r_rdPtr + 1'b1;
      end
    end
  end

  // Occupancy stays constant when a push and a pop land in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges the in-order pipeline and a buffered
// long-latency unit onto the single register-file write port, tracks
// outstanding long-latency destinations for ID hazard checks, and asks ID
// for a bubble when buffered results keep losing arbitration.
module writeback_arbiter
  import riscv_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst_n,
  writeback_arbiter_if.slave bus
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_LIMIT - 1);

  wb_req_t w_aluReq;
  wb_req_t w_lsuReq;
  wb_req_t w_head;
  wb_req_t w_win;

  logic w_full;
  logic w_empty;
  logic w_aluWin;
  logic w_headWin;
  logic w_bypassWin;
  logic w_lsuWin;
  logic w_anyWin;
  logic w_lsuAccept;
  logic w_push;
  logic w_pop;

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pendingNext;
  logic [STARVE_W-1:0] r_starveCnt;

  logic              r_regWrite;
  logic [ADDR_W-1:0] r_writeReg;
  logic [DATA_W-1:0] r_writeData;
  logic              r_aluStall;

  assign w_aluReq = {bus.AluRd, bus.AluData};
  assign w_lsuReq = {bus.LsuRd, bus.LsuData};

  // Priority: pipeline, then buffered head, then a direct LSU bypass into an empty buffer.
  assign w_aluWin    = bus.AluValid;
  assign w_headWin   = !bus.AluValid && !w_empty;
  assign w_bypassWin = !bus.AluValid && w_empty && bus.LsuValid;
  assign w_lsuWin    = w_headWin || w_bypassWin;
  assign w_anyWin    = w_aluWin || w_lsuWin;

  // A bypassed request is consumed immediately and never occupies a slot.
  assign w_lsuAccept = bus.LsuValid && !w_full;
  assign w_push      = w_lsuAccept && !w_bypassWin;
  assign w_pop       = w_headWin;

  assign bus.LsuReady = !w_full;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_lsuReq),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Select the request that owns the write port this cycle.
  always_comb begin
    w_win = '0;
    if (w_aluWin) begin
      w_win = w_aluReq;
    end else if (w_headWin) begin
      w_win = w_head;
    end else if (w_bypassWin) begin
      w_win = w_lsuReq;
    end
  end

  // Register the winner onto the write port; x0 winners consume the slot but write nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regWrite  <= 1'b0;
      r_writeReg  <= '0;
      r_writeData <= '0;
    end else if (w_anyWin && !is_zero_rd(w_win.rd)) begin
      r_regWrite  <= 1'b1;
      r_writeReg  <= w_win.rd;
      r_writeData <= w_win.data;
    end else begin
      r_regWrite  <= 1'b0;
      r_writeReg  <= '0;
      r_writeData <= '0;
    end
  end

  // Next pending vector: a long-latency completion clears, a new issue sets, and set wins.
  always_comb begin
    w_pendingNext = r_pending;
    if (w_lsuWin) begin
      w_pendingNext[w_win.rd] = 1'b0;
    end
    if (bus.IssueValid && !is_zero_rd(bus.IssueRd)) begin
      w_pendingNext[bus.IssueRd] = 1'b1;
    end
  end

  // Pending-destination scoreboard used by ID for RAW hazard stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pendingNext;
    end
  end

  // Count consecutive cycles the buffered head loses to the pipeline; request one bubble at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starveCnt <= '0;
      r_aluStall  <= 1'b0;
    end else begin
      r_aluStall <= 1'b0;
      if (!w_empty && w_aluWin) begin
        if (r_starveCnt == STARVE_LAST) begin
          r_starveCnt <= '0;
          r_aluStall  <= 1'b1;
        end else begin
          r_starveCnt <= r_starveCnt + 1'b1;
        end
      end else begin
        r_starveCnt <= '0;
      end
    end
  end

  assign bus.Rs1Pending    = !is_zero_rd(bus.QueryRs1) && r_pending[bus.QueryRs1];
  assign bus.Rs2Pending    = !is_zero_rd(bus.QueryRs2) && r_pending[bus.QueryRs2];
  assign bus.AluStall      = r_aluStall;
  assign bus.RegWrite      = r_regWrite;
  assign bus.WriteRegister = r_writeReg;
  assign bus.WriteData     = r_writeData;

endmodule
